// File: rtl/gb_stream_src.sv
// -----------------------------------------------------------------------------
// gb_stream_src
//
// Test-pattern frame source with an AXI4-Stream master output. A single-cycle
// start (honoured only while idle) latches the frame geometry, pattern mode
// and seed. The block then emits img_w*img_h pixels in raster order at up to
// one beat per cycle and pulses done for one cycle at frame end. A frame with
// a zero dimension emits no beats and goes straight to the done cycle.
//
// Parameters
//   LAST_PER_LINE : 1 = TLAST on every row end, 0 = TLAST on final pixel only
//   DIM_W         : width of img_w / img_h and of the x/y coordinates
//
// Ports
//   ap_clk        : clock, all state on rising edge
//   ap_rst_n      : asynchronous active-low reset
//   start         : frame request pulse (ignored unless idle)
//   img_w, img_h  : frame width / height, sampled on accepted start
//   mode          : 0 = x+y, 1 = seed, 2 = LFSR, 3 = x^y
//   seed          : pattern constant / LFSR seed, sampled on accepted start
//   arg_1_TDATA   : stream pixel data
//   arg_1_TVALID  : stream valid
//   arg_1_TLAST   : stream last
//   arg_1_TREADY  : stream ready from the sink
//   busy          : high while a frame is in progress (SEND or FIN)
//   done          : one-cycle pulse at frame end
//   pix_cnt       : handshaken beats in the current / last frame (saturating)
// -----------------------------------------------------------------------------
module gb_stream_src #(
    parameter int LAST_PER_LINE = 0,
    parameter int DIM_W         = 10
) (
    input  logic             ap_clk,
    input  logic             ap_rst_n,
    input  logic             start,
    input  logic [DIM_W-1:0] img_w,
    input  logic [DIM_W-1:0] img_h,
    input  logic [1:0]       mode,
    input  logic [7:0]       seed,
    output logic [7:0]       arg_1_TDATA,
    output logic             arg_1_TVALID,
    output logic             arg_1_TLAST,
    input  logic             arg_1_TREADY,
    output logic             busy,
    output logic             done,
    output logic [18:0]      pix_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_FIN  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [DIM_W-1:0] w_q, w_d;
    logic [DIM_W-1:0] h_q, h_d;
    logic [1:0]       mode_q, mode_d;
    logic [7:0]       seed_q, seed_d;
    logic [DIM_W-1:0] x_q, x_d;
    logic [DIM_W-1:0] y_q, y_d;
    logic [7:0]       lfsr_q, lfsr_d;
    logic [18:0]      cnt_q, cnt_d;

    logic             hs;
    logic             x_last;
    logic             y_last;
    logic [7:0]       pix;

    // Beat counter saturates instead of wrapping.
    function automatic logic [18:0] sat_inc(input logic [18:0] v);
        return (v == '1) ? v : v + 19'd1;
    endfunction

    // Fibonacci LFSR x^8+x^6+x^5+x^4+1, shift left, feedback into bit 0.
    function automatic logic [7:0] lfsr_step(input logic [7:0] v);
        return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
    endfunction

    // w_q/h_q are never zero while in SEND, so the -1 cannot underflow there.
    assign x_last = (x_q == w_q - DIM_W'(1));
    assign y_last = (y_q == h_q - DIM_W'(1));

    // TVALID comes purely from state, never from TREADY; everything the beat
    // carries is registered and only moves on a handshake, so it stays stable
    // through stalls.
    assign arg_1_TVALID = (state_q == ST_SEND);
    assign hs           = arg_1_TVALID && arg_1_TREADY;

    always_comb begin
        pix = 8'h00;
        case (mode_q)
            2'd0:    pix = 8'(x_q) + 8'(y_q);
            2'd1:    pix = seed_q;
            2'd2:    pix = lfsr_q;
            default: pix = 8'(x_q) ^ 8'(y_q);
        endcase
    end

    // Data is forced to zero outside SEND so reset and idle show a clean bus.
    assign arg_1_TDATA = arg_1_TVALID ? pix : 8'h00;
    assign arg_1_TLAST = arg_1_TVALID && x_last && (y_last || (LAST_PER_LINE != 0));
    assign busy        = (state_q != ST_IDLE);
    assign done        = (state_q == ST_FIN);
    assign pix_cnt     = cnt_q;

    always_comb begin
        state_d = state_q;
        w_d     = w_q;
        h_d     = h_q;
        mode_d  = mode_q;
        seed_d  = seed_q;
        x_d     = x_q;
        y_d     = y_q;
        lfsr_d  = lfsr_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    w_d    = img_w;
                    h_d    = img_h;
                    mode_d = mode;
                    seed_d = seed;
                    x_d    = '0;
                    y_d    = '0;
                    cnt_d  = '0;
                    // An all-zero LFSR would lock up; substitute 1.
                    lfsr_d = (seed == 8'h00) ? 8'h01 : seed;
                    if (img_w == '0 || img_h == '0) begin
                        state_d = ST_FIN;
                    end else begin
                        state_d = ST_SEND;
                    end
                end
            end
            ST_SEND: begin
                if (hs) begin
                    cnt_d  = sat_inc(cnt_q);
                    lfsr_d = lfsr_step(lfsr_q);
                    if (x_last) begin
                        x_d = '0;
                        if (y_last) begin
                            y_d     = '0;
                            state_d = ST_FIN;
                        end else begin
                            y_d = y_q + DIM_W'(1);
                        end
                    end else begin
                        x_d = x_q + DIM_W'(1);
                    end
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Control and coordinate state: asynchronously reset.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_q <= ST_IDLE;
            x_q     <= '0;
            y_q     <= '0;
            lfsr_q  <= 8'h01;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            lfsr_q  <= lfsr_d;
            cnt_q   <= cnt_d;
        end
    end

    // Frame parameters: only read while in SEND, always loaded before use.
    always_ff @(posedge ap_clk) begin
        w_q    <= w_d;
        h_q    <= h_d;
        mode_q <= mode_d;
        seed_q <= seed_d;
    end

endmodule

// File: tb/tb_gb_stream_src.sv
module tb_gb_stream_src;

    localparam int DIM_W = 10;

    logic             ap_clk   = 1'b0;
    logic             ap_rst_n = 1'b1;
    logic             start    = 1'b0;
    logic [DIM_W-1:0] img_w    = '0;
    logic [DIM_W-1:0] img_h    = '0;
    logic [1:0]       mode     = '0;
    logic [7:0]       seed     = '0;
    logic             tready   = 1'b0;

    logic [7:0]  d0, d1;
    logic        v0, v1, l0, l1, busy0, busy1, done0, done1;
    logic [18:0] pc0, pc1;

    int errors = 0;
    int checks = 0;

    // Scoreboard: expected beats pushed at start, received beats collected.
    int exp_d[$];
    bit exp_l0[$];
    bit exp_l1[$];
    int rx_d[$];
    bit rx_l0[$];
    bit rx_l1[$];
    int rx_pc[$];

    // Per-frame observations.
    int first_vld, done_cyc, vld_at_done, viol, post_bad;

    gb_stream_src #(.LAST_PER_LINE(0), .DIM_W(DIM_W)) dut (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .start(start),
        .img_w(img_w), .img_h(img_h), .mode(mode), .seed(seed),
        .arg_1_TDATA(d0), .arg_1_TVALID(v0), .arg_1_TLAST(l0), .arg_1_TREADY(tready),
        .busy(busy0), .done(done0), .pix_cnt(pc0)
    );

    gb_stream_src #(.LAST_PER_LINE(1), .DIM_W(DIM_W)) dut_l (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .start(start),
        .img_w(img_w), .img_h(img_h), .mode(mode), .seed(seed),
        .arg_1_TDATA(d1), .arg_1_TVALID(v1), .arg_1_TLAST(l1), .arg_1_TREADY(tready),
        .busy(busy1), .done(done1), .pix_cnt(pc1)
    );

    always #5 ap_clk = ~ap_clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic bit rdy(input int pat, input int k);
        if (pat == 0) return 1'b1;
        return (k % 4 == 0) || (k % 4 == 3);
    endfunction

    task automatic flush();
        exp_d.delete(); exp_l0.delete(); exp_l1.delete();
        rx_d.delete(); rx_l0.delete(); rx_l1.delete(); rx_pc.delete();
    endtask

    // Builds the expected raster-order beats, then pulses start for one edge.
    task automatic do_start(input int w, input int h, input int m, input int s, input int pat);
        logic [7:0] lf;
        logic [7:0] d;
        lf = (s == 0) ? 8'h01 : 8'(s);
        for (int yy = 0; yy < h; yy++) begin
            for (int xx = 0; xx < w; xx++) begin
                case (m)
                    0:       d = 8'(xx + yy);
                    1:       d = 8'(s);
                    2:       begin d = lf; lf = {lf[6:0], ^(lf & 8'hB8)}; end
                    default: d = 8'(xx) ^ 8'(yy);
                endcase
                exp_d.push_back(int'(d));
                exp_l0.push_back((xx == w - 1) && (yy == h - 1));
                exp_l1.push_back(xx == w - 1);
            end
        end
        @(posedge ap_clk); #1;
        img_w  = DIM_W'(w);
        img_h  = DIM_W'(h);
        mode   = 2'(m);
        seed   = 8'(s);
        tready = rdy(pat, 0);
        start  = 1'b1;
        @(posedge ap_clk); #1;
        start  = 1'b0;
    endtask

    // Runs the frame under a ready pattern, recording beats and protocol
    // observations; optionally pokes a (to-be-ignored) start at cycle 'poke'.
    task automatic collect(input int pat, input int poke, input int maxc);
        logic [7:0] hd;
        logic       hl;
        bit         stalled;
        bit         seen;
        first_vld = -1; done_cyc = -1; vld_at_done = -1; viol = 0; post_bad = 0;
        stalled = 1'b0; seen = 1'b0; hd = 8'h00; hl = 1'b0;
        if (poke == 0) begin start = 1'b1; img_w = 3; img_h = 3; end
        for (int cyc = 0; cyc < maxc && !seen; cyc++) begin
            @(negedge ap_clk);
            if (v0 && first_vld < 0) first_vld = cyc;
            if (stalled && (!v0 || d0 !== hd || l0 !== hl)) viol++;
            if (v0 !== v1 || d0 !== d1 || pc0 !== pc1 || busy0 !== busy1 || done0 !== done1) viol++;
            if (v0 && tready) begin
                rx_d.push_back(int'(d0));
                rx_l0.push_back(l0);
                rx_l1.push_back(l1);
                rx_pc.push_back(int'(pc0));
            end
            stalled = v0 && !tready;
            hd = d0;
            hl = l0;
            if (done0) begin seen = 1'b1; done_cyc = cyc; vld_at_done = int'(v0); end
            @(posedge ap_clk); #1;
            tready = rdy(pat, cyc + 1);
            start  = (cyc + 1 == poke);
            if (start) begin img_w = 3; img_h = 3; end
        end
        start = 1'b0;
        repeat (3) begin
            @(negedge ap_clk);
            if (v0 || done0 || busy0) post_bad++;
        end
    endtask

    task automatic test_reset();
        #1 ap_rst_n = 1'b0;
        #1;
        checks++; if (v0 !== 1'b0) begin errors++; $display("FAIL reset_tvalid: got %b want 0", v0); end
        checks++; if (l0 !== 1'b0) begin errors++; $display("FAIL reset_tlast: got %b want 0", l0); end
        checks++; if (d0 !== 8'h00) begin errors++; $display("FAIL reset_tdata: got %h want 00", d0); end
        checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy0); end
        checks++; if (done0 !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done0); end
        checks++; if (pc0 !== 19'd0) begin errors++; $display("FAIL reset_pixcnt: got %0d want 0", pc0); end
        img_w = 2; img_h = 2; start = 1'b1;
        repeat (2) @(posedge ap_clk);
        #1;
        checks++; if (v0 !== 1'b0 || busy0 !== 1'b0) begin errors++; $display("FAIL reset_start_ignored: got valid=%b busy=%b want 0 0", v0, busy0); end
        start = 1'b0;
        ap_rst_n = 1'b1;
        @(posedge ap_clk); #1;
        checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL reset_release_idle: got busy=%b want 0", busy0); end
    endtask

    task automatic test_mode0_full();
        int ed, rd, rpc, n;
        bit el0, el1, rl0, rl1;
        flush();
        do_start(4, 2, 0, 0, 0);
        collect(0, -1, 60);
        n = 0;
        while (exp_d.size() > 0 && rx_d.size() > 0) begin
            ed = exp_d.pop_front(); el0 = exp_l0.pop_front(); el1 = exp_l1.pop_front();
            rd = rx_d.pop_front(); rl0 = rx_l0.pop_front(); rl1 = rx_l1.pop_front(); rpc = rx_pc.pop_front();
            checks++;
            if (rd !== ed || rl0 !== el0 || rl1 !== el1 || rpc !== n) begin
                errors++;
                $display("FAIL mode0_beat%0d: got d=%h l=%b/%b pc=%0d want d=%h l=%b/%b pc=%0d", n, rd, rl0, rl1, rpc, ed, el0, el1, n);
            end
            n++;
        end
        checks++; if (exp_d.size() != 0 || rx_d.size() != 0) begin errors++; $display("FAIL mode0_count: got %0d beats want 8", n + rx_d.size()); end
        checks++; if (first_vld != 0) begin errors++; $display("FAIL mode0_first_valid: got cycle %0d want 0", first_vld); end
        checks++; if (done_cyc != 8) begin errors++; $display("FAIL mode0_done_cycle: got %0d want 8", done_cyc); end
        checks++; if (vld_at_done != 0) begin errors++; $display("FAIL mode0_valid_at_done: got %0d want 0", vld_at_done); end
        checks++; if (post_bad != 0 || viol != 0) begin errors++; $display("FAIL mode0_protocol: got post=%0d viol=%0d want 0 0", post_bad, viol); end
        checks++; if (pc0 !== 19'd8) begin errors++; $display("FAIL mode0_pixcnt: got %0d want 8", pc0); end
    endtask

    task automatic test_stall();
        int ed, rd, rpc, n;
        bit el0, el1, rl0, rl1;
        flush();
        do_start(4, 2, 0, 0, 1);
        collect(1, 3, 80);
        n = 0;
        while (exp_d.size() > 0 && rx_d.size() > 0) begin
            ed = exp_d.pop_front(); el0 = exp_l0.pop_front(); el1 = exp_l1.pop_front();
            rd = rx_d.pop_front(); rl0 = rx_l0.pop_front(); rl1 = rx_l1.pop_front(); rpc = rx_pc.pop_front();
            checks++;
            if (rd !== ed || rl0 !== el0 || rl1 !== el1 || rpc !== n) begin
                errors++;
                $display("FAIL stall_beat%0d: got d=%h l=%b/%b pc=%0d want d=%h l=%b/%b pc=%0d", n, rd, rl0, rl1, rpc, ed, el0, el1, n);
            end
            n++;
        end
        checks++; if (exp_d.size() != 0 || rx_d.size() != 0) begin errors++; $display("FAIL stall_count: got %0d beats want 8", n + rx_d.size()); end
        checks++; if (viol != 0) begin errors++; $display("FAIL stall_stability: got %0d violations want 0", viol); end
        checks++; if (done_cyc != 16) begin errors++; $display("FAIL stall_done_cycle: got %0d want 16", done_cyc); end
        checks++; if (post_bad != 0 || pc0 !== 19'd8) begin errors++; $display("FAIL stall_end: got post=%0d pc=%0d want 0 8", post_bad, pc0); end
    endtask

    task automatic test_line_last();
        int ed, rd, rpc, n;
        bit el0, el1, rl0, rl1;
        flush();
        do_start(3, 3, 3, 0, 0);
        collect(0, -1, 60);
        n = 0;
        while (exp_d.size() > 0 && rx_d.size() > 0) begin
            ed = exp_d.pop_front(); el0 = exp_l0.pop_front(); el1 = exp_l1.pop_front();
            rd = rx_d.pop_front(); rl0 = rx_l0.pop_front(); rl1 = rx_l1.pop_front(); rpc = rx_pc.pop_front();
            checks++;
            if (rd !== ed || rl0 !== el0 || rl1 !== el1 || rpc !== n) begin
                errors++;
                $display("FAIL xor_beat%0d: got d=%h l=%b/%b pc=%0d want d=%h l=%b/%b pc=%0d", n, rd, rl0, rl1, rpc, ed, el0, el1, n);
            end
            n++;
        end
        checks++; if (exp_d.size() != 0 || rx_d.size() != 0) begin errors++; $display("FAIL xor_count: got %0d beats want 9", n + rx_d.size()); end
        checks++; if (done_cyc != 9 || viol != 0 || post_bad != 0) begin errors++; $display("FAIL xor_end: got done=%0d viol=%0d post=%0d want 9 0 0", done_cyc, viol, post_bad); end
    endtask

    task automatic test_lfsr();
        int ed, rd, rpc, n;
        bit el0, el1, rl0, rl1;
        int want[3];
        want = '{32'h01, 32'h02, 32'h04};
        flush();
        do_start(3, 1, 2, 0, 0);
        collect(0, -1, 40);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (rx_d.size() <= i || rx_d[i] != want[i]) begin
                errors++;
                $display("FAIL lfsr_seed0_beat%0d: got %0h want %0h", i, (rx_d.size() > i) ? rx_d[i] : -1, want[i]);
            end
        end
        // Seed FF continues the scoreboard with LFSR, then a constant-seed frame.
        do_start(3, 1, 2, 255, 0);
        collect(0, -1, 40);
        do_start(2, 2, 1, 165, 0);
        collect(0, -1, 40);
        n = 0;
        while (exp_d.size() > 0 && rx_d.size() > 0) begin
            ed = exp_d.pop_front(); el0 = exp_l0.pop_front(); el1 = exp_l1.pop_front();
            rd = rx_d.pop_front(); rl0 = rx_l0.pop_front(); rl1 = rx_l1.pop_front(); rpc = rx_pc.pop_front();
            checks++;
            if (rd !== ed || rl0 !== el0 || rl1 !== el1) begin
                errors++;
                $display("FAIL lfsr_seed_beat%0d: got d=%h l=%b/%b pc=%0d want d=%h l=%b/%b", n, rd, rl0, rl1, rpc, ed, el0, el1);
            end
            n++;
        end
        checks++; if (exp_d.size() != 0 || rx_d.size() != 0) begin errors++; $display("FAIL lfsr_count: got %0d beats want 10", n + rx_d.size()); end
        checks++; if (pc0 !== 19'd4) begin errors++; $display("FAIL seed_pixcnt: got %0d want 4", pc0); end
    endtask

    task automatic test_zero_dim();
        flush();
        do_start(0, 5, 0, 0, 0);
        collect(0, 0, 10);
        checks++; if (first_vld != -1 || rx_d.size() != 0) begin errors++; $display("FAIL zero_w_no_beats: got first_valid=%0d beats=%0d want -1 0", first_vld, rx_d.size()); end
        checks++; if (done_cyc != 0) begin errors++; $display("FAIL zero_w_done_cycle: got %0d want 0", done_cyc); end
        checks++; if (post_bad != 0) begin errors++; $display("FAIL zero_w_start_in_fin: got %0d bad cycles want 0", post_bad); end
        checks++; if (pc0 !== 19'd0) begin errors++; $display("FAIL zero_w_pixcnt: got %0d want 0", pc0); end
        flush();
        do_start(3, 0, 0, 0, 0);
        collect(0, -1, 10);
        checks++; if (first_vld != -1 || done_cyc != 0 || post_bad != 0) begin errors++; $display("FAIL zero_h: got first_valid=%0d done=%0d post=%0d want -1 0 0", first_vld, done_cyc, post_bad); end
    endtask

    task automatic test_reset_midframe();
        int ed, rd, rpc, n, bad;
        bit el0, el1, rl0, rl1;
        flush();
        do_start(4, 4, 0, 0, 0);
        repeat (3) @(posedge ap_clk);
        #1;
        checks++; if (pc0 !== 19'd3 || v0 !== 1'b1) begin errors++; $display("FAIL midrst_before: got pc=%0d valid=%b want 3 1", pc0, v0); end
        ap_rst_n = 1'b0;
        #1;
        checks++; if (v0 !== 1'b0 || busy0 !== 1'b0 || pc0 !== 19'd0 || d0 !== 8'h00) begin
            errors++; $display("FAIL midrst_async: got valid=%b busy=%b pc=%0d d=%h want 0 0 0 00", v0, busy0, pc0, d0);
        end
        repeat (2) @(posedge ap_clk);
        #1 ap_rst_n = 1'b1;
        bad = 0;
        repeat (4) begin
            @(negedge ap_clk);
            if (v0 || busy0 || done0) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL midrst_idle_after: got %0d active cycles want 0", bad); end
        flush();
        do_start(2, 2, 0, 0, 0);
        collect(0, -1, 40);
        n = 0;
        while (exp_d.size() > 0 && rx_d.size() > 0) begin
            ed = exp_d.pop_front(); el0 = exp_l0.pop_front(); el1 = exp_l1.pop_front();
            rd = rx_d.pop_front(); rl0 = rx_l0.pop_front(); rl1 = rx_l1.pop_front(); rpc = rx_pc.pop_front();
            checks++;
            if (rd !== ed || rl0 !== el0 || rl1 !== el1 || rpc !== n) begin
                errors++;
                $display("FAIL midrst_beat%0d: got d=%h l=%b/%b pc=%0d want d=%h l=%b/%b pc=%0d", n, rd, rl0, rl1, rpc, ed, el0, el1, n);
            end
            n++;
        end
        checks++; if (exp_d.size() != 0 || rx_d.size() != 0) begin errors++; $display("FAIL midrst_count: got %0d beats want 4", n + rx_d.size()); end
        checks++; if (done_cyc != 4 || pc0 !== 19'd4) begin errors++; $display("FAIL midrst_end: got done=%0d pc=%0d want 4 4", done_cyc, pc0); end
    endtask

    initial begin
        test_reset();
        test_mode0_full();
        test_stall();
        test_line_last();
        test_lfsr();
        test_zero_dim();
        test_reset_midframe();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
